// File: rtl/deserializer_pkg.sv
// Shared serial-link definitions: FSM encodings and frame geometry helpers.
`default_nettype none

package deserializer_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    // Start bit + data bits + stop bit; the serializer uses the same value.
    function automatic int frame_len(input int width);
        return width + 2;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/deser_bit_timer.sv
// Loadable down-counter that paces serial bit sampling; expire_o is high at count 0.
`default_nettype none

module deser_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          load_i,
    input  logic [$clog2(CLKS_PER_BIT):0] load_val_i,
    output logic                          expire_o
);

    localparam int TW = $clog2(CLKS_PER_BIT) + 1;

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - TW'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/deserializer.sv
// Serial frame receiver: start/data/stop framing check, one-entry holding
// register with ready/rd handshake, overrun and frame-error flags.
`default_nettype none

module deserializer
    import deserializer_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             in_i,
    output logic [WIDTH-1:0] data_o,
    output logic             ready_o,
    input  logic             rd_i,
    output logic             frame_err_o,
    output logic             overrun_o,
    output logic             busy_o
);

    localparam int TW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW   = idx_width(WIDTH);
    localparam int HALF = CLKS_PER_BIT / 2;

    // The timer expires one edge after it reads 0, so loads are one less than the wait.
    localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX  = IW'(WIDTH - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               ready_q, ready_d;
    logic               overrun_q, overrun_d;
    logic               frame_err_q, frame_err_d;
    logic               timer_load;
    logic [TW-1:0]      timer_val;
    logic               expire;

    deser_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .expire_o   (expire)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        ready_d     = ready_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        timer_load  = 1'b0;
        timer_val   = BIT_LOAD;

        if (rd_i && ready_q) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!in_i) begin
                    timer_load = 1'b1;
                    idx_d      = '0;
                    // With under two clocks per bit the detection sample is the mid-bit check.
                    if (HALF == 0) begin
                        state_d   = ST_DATA;
                        timer_val = BIT_LOAD;
                    end else begin
                        state_d   = ST_START;
                        timer_val = HALF_LOAD;
                    end
                end
            end
            ST_START: begin
                if (expire) begin
                    if (!in_i) begin
                        state_d    = ST_DATA;
                        timer_load = 1'b1;
                        timer_val  = BIT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (expire) begin
                    shift_d[idx_q] = in_i;
                    timer_load     = 1'b1;
                    timer_val      = BIT_LOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (expire) begin
                    if (in_i) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        if (ready_q && !rd_i) begin
                            overrun_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (in_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data_o      = data_q;
    assign ready_o     = ready_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

endmodule

`default_nettype wire

// File: tb/tb_deserializer.sv
// Directed bench for deserializer at one and four clocks per bit.
`default_nettype none

module tb_deserializer;

    logic       clk;
    logic       rst;
    logic       in1, in4;
    logic       rd1, rd4;
    logic [7:0] data1, data4;
    logic       ready1, ready4;
    logic       ferr1, ferr4;
    logic       ovr1, ovr4;
    logic       busy1, busy4;

    int n_checks = 0;
    int n_pass   = 0;

    deserializer #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clock_i     (clk),
        .reset_i     (rst),
        .in_i        (in1),
        .data_o      (data1),
        .ready_o     (ready1),
        .rd_i        (rd1),
        .frame_err_o (ferr1),
        .overrun_o   (ovr1),
        .busy_o      (busy1)
    );

    deserializer #(.WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
        .clock_i     (clk),
        .reset_i     (rst),
        .in_i        (in4),
        .data_o      (data4),
        .ready_o     (ready4),
        .rd_i        (rd4),
        .frame_err_o (ferr4),
        .overrun_o   (ovr4),
        .busy_o      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One N=1 frame; the line is left at the stop-bit level.
    task automatic send1(input logic [7:0] d, input logic stop_bit, input logic rd_at_start);
        in1 = 1'b0;
        rd1 = rd_at_start;
        tick();
        rd1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in1 = d[i];
            tick();
        end
        in1 = stop_bit;
        tick();
    endtask

    initial begin
        logic [9:0] vec;
        logic [7:0] d;
        int ferr_seen;
        int busy_seen;

        rst = 1'b1; in1 = 1'b1; in4 = 1'b1; rd1 = 1'b0; rd4 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_data1",  {24'd0, data1}, 32'h0);
        check("rst_ready1", {31'd0, ready1}, 32'd0);
        check("rst_busy1",  {31'd0, busy1}, 32'd0);
        check("rst_ferr1",  {31'd0, ferr1}, 32'd0);
        check("rst_ovr1",   {31'd0, ovr1}, 32'd0);
        check("rst_data4",  {24'd0, data4}, 32'h0);
        check("rst_busy4",  {31'd0, busy4}, 32'd0);

        // 0xA5 frame: start, 1,0,1,0,0,1,0,1, stop
        vec = 10'b11_0100_1010;
        for (int i = 0; i < 10; i++) begin
            in1 = vec[i];
            tick();
            if (i == 0) check("a5_busy_k", {31'd0, busy1}, 32'd1);
            if (i == 8) check("a5_ready_k8", {31'd0, ready1}, 32'd0);
        end
        check("a5_data",  {24'd0, data1}, 32'hA5);
        check("a5_ready", {31'd0, ready1}, 32'd1);
        check("a5_busy",  {31'd0, busy1}, 32'd0);
        rd1 = 1'b1;
        tick();
        rd1 = 1'b0;
        check("a5_rd_ready", {31'd0, ready1}, 32'd0);

        // Loopback-style back-to-back frames, consumer reads at the second start.
        send1(8'h3C, 1'b1, 1'b0);
        check("lb_3c_data",  {24'd0, data1}, 32'h3C);
        check("lb_3c_ready", {31'd0, ready1}, 32'd1);
        send1(8'hFF, 1'b1, 1'b1);
        check("lb_ff_data",  {24'd0, data1}, 32'hFF);
        check("lb_ff_ready", {31'd0, ready1}, 32'd1);
        check("lb_ff_ovr",   {31'd0, ovr1}, 32'd0);
        check("lb_ff_ferr",  {31'd0, ferr1}, 32'd0);
        rd1 = 1'b1;
        tick();
        rd1 = 1'b0;

        // Bad stop bit, then line held low (break).
        send1(8'h55, 1'b0, 1'b0);
        check("fe_pulse", {31'd0, ferr1}, 32'd1);
        check("fe_ready", {31'd0, ready1}, 32'd0);
        check("fe_data",  {24'd0, data1}, 32'hFF);
        ferr_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            ferr_seen += int'(ferr1);
            busy_seen += int'(busy1);
        end
        check("fe_no_more_ferr", ferr_seen, 0);
        check("fe_no_busy", busy_seen, 0);
        in1 = 1'b1;
        tick(); tick();
        check("fe_idle_busy", {31'd0, busy1}, 32'd0);

        // Overrun: two unread frames, then a read.
        send1(8'h11, 1'b1, 1'b0);
        send1(8'h22, 1'b1, 1'b0);
        check("ov_data",  {24'd0, data1}, 32'h22);
        check("ov_ready", {31'd0, ready1}, 32'd1);
        check("ov_flag",  {31'd0, ovr1}, 32'd1);
        rd1 = 1'b1;
        tick();
        rd1 = 1'b0;
        check("ov_rd_ready", {31'd0, ready1}, 32'd0);
        check("ov_rd_flag",  {31'd0, ovr1}, 32'd0);

        // Reset during data bit 4, with an unread word held.
        send1(8'h5A, 1'b1, 1'b0);
        check("rm_pre_ready", {31'd0, ready1}, 32'd1);
        d = 8'hE7;
        in1 = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            in1 = d[i];
            tick();
        end
        in1 = d[4];
        check("rm_pre_busy", {31'd0, busy1}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rm_data",  {24'd0, data1}, 32'h0);
        check("rm_ready", {31'd0, ready1}, 32'd0);
        check("rm_busy",  {31'd0, busy1}, 32'd0);
        check("rm_ovr",   {31'd0, ovr1}, 32'd0);
        check("rm_ferr",  {31'd0, ferr1}, 32'd0);
        tick();
        rst = 1'b0;
        in1 = 1'b1;
        tick(); tick();
        send1(8'h81, 1'b1, 1'b0);
        check("rm_81_data",  {24'd0, data1}, 32'h81);
        check("rm_81_ready", {31'd0, ready1}, 32'd1);
        check("rm_81_ferr",  {31'd0, ferr1}, 32'd0);

        // N=4: one-cycle glitch is rejected at mid-bit.
        in4 = 1'b0;
        tick();
        check("g4_busy_k", {31'd0, busy4}, 32'd1);
        in4 = 1'b1;
        tick(); tick();
        check("g4_busy_mid", {31'd0, busy4}, 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("g4_ready", {31'd0, ready4}, 32'd0);
        check("g4_busy_late", {31'd0, busy4}, 32'd0);

        // N=4: proper 0xC3 frame; ready after edge k+38.
        d = 8'hC3;
        in4 = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        for (int i = 0; i < 8; i++) begin
            in4 = d[i];
            for (int c = 0; c < 4; c++) tick();
        end
        in4 = 1'b1;
        tick(); tick();
        check("c3_ready_k37", {31'd0, ready4}, 32'd0);
        check("c3_busy_k37",  {31'd0, busy4}, 32'd1);
        tick();
        check("c3_ready_k38", {31'd0, ready4}, 32'd1);
        check("c3_data",      {24'd0, data4}, 32'hC3);
        check("c3_busy",      {31'd0, busy4}, 32'd0);
        check("c3_ferr",      {31'd0, ferr4}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
